// File: rtl/fetch_pc_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pc_queue_pkg
// Shared constants for the instruction-fetch front end:
//   ADDR_BUS / DATA_BUS  default PC and instruction widths
//   INIT_PC_DEFAULT      first fetch address after reset
//   PC_STEP              byte distance between sequential instructions
//   ptr_width()          width of a queue pointer that can tell full from empty
// -----------------------------------------------------------------------------
package fetch_pc_queue_pkg;

    localparam int ADDR_BUS = 32;
    localparam int DATA_BUS = 32;

    localparam logic [ADDR_BUS-1:0] INIT_PC_DEFAULT = 32'h0000_1000;

    localparam int PC_STEP = 4;

    // One extra bit above the index lets (a - b) range over 0..depth.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_pc_queue_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// In-order buffer of fetch entries {pc, inst, filled}.
//   clear      drop every entry (pointers equal, filled bits cleared)
//   alloc      append an entry at the tail with pc = alloc_pc, unfilled
//   fill       write fill_inst into the oldest unfilled entry
//   pop        retire the head entry
//   count      allocated entries not yet popped
//   unfilled   allocated entries still waiting for their instruction
//   head_*     contents of the head entry (meaningful only when count > 0)
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_pc_queue_pkg::*;
#(
    parameter  int ADDR_WIDTH = ADDR_BUS,
    parameter  int DATA_WIDTH = DATA_BUS,
    parameter  int DEPTH      = 4,
    localparam int PW         = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  alloc,
    input  logic [ADDR_WIDTH-1:0] alloc_pc,
    input  logic                  fill,
    input  logic [DATA_WIDTH-1:0] fill_inst,
    input  logic                  pop,
    output logic [PW-1:0]         count,
    output logic [PW-1:0]         unfilled,
    output logic [ADDR_WIDTH-1:0] head_pc,
    output logic [DATA_WIDTH-1:0] head_inst,
    output logic                  head_filled
);

    localparam int IW = $clog2(DEPTH);

    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] inst_mem [DEPTH];
    logic [DEPTH-1:0]      filled;
    logic [PW-1:0]         alloc_ptr;
    logic [PW-1:0]         fill_ptr;
    logic [PW-1:0]         head_ptr;

    // NOTE: the payload arrays carry no reset; the pointers and filled bits
    // alone decide which entries are live, so stale payload is never seen.
    always_ff @(posedge clk) begin
        if (alloc) pc_mem[alloc_ptr[IW-1:0]]  <= alloc_pc;
        if (fill)  inst_mem[fill_ptr[IW-1:0]] <= fill_inst;
    end

    // NOTE: all state uses non-blocking assignment so every update in this
    // block sees the pre-edge pointer values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            filled    <= '0;
        end else begin
            // alloc, fill and pop always address three different entries:
            // fill targets an already-allocated slot, pop needs a filled one.
            if (alloc) begin
                alloc_ptr                   <= alloc_ptr + PW'(1);
                filled[alloc_ptr[IW-1:0]]   <= 1'b0;
            end
            if (fill) begin
                fill_ptr                    <= fill_ptr + PW'(1);
                filled[fill_ptr[IW-1:0]]    <= 1'b1;
            end
            if (pop) begin
                head_ptr                    <= head_ptr + PW'(1);
            end
        end
    end

    assign count       = alloc_ptr - head_ptr;
    assign unfilled    = alloc_ptr - fill_ptr;
    assign head_pc     = pc_mem[head_ptr[IW-1:0]];
    assign head_inst   = inst_mem[head_ptr[IW-1:0]];
    assign head_filled = filled[head_ptr[IW-1:0]];

endmodule

// File: rtl/fetch_pc_queue.sv
// -----------------------------------------------------------------------------
// fetch_pc_queue
// Instruction-fetch front end between the instruction ROM and ID.
//   clk, rst                          clock, synchronous active-high reset
//   flush, exc_pc                     exception redirect (highest priority)
//   branch_flag, branch_addr          branch redirect from ID
//   rom_req, rom_gnt, rom_addr        pipelined request handshake to the ROM
//   rom_rvalid, rom_rdata             in-order ROM responses (latency >= 1)
//   id_valid, id_ready, id_pc, id_inst  head of the fetch queue towards ID
// Requests are limited so that queued entries plus responses still to be
// dropped never exceed DEPTH. A redirect empties the queue and remembers how
// many in-flight responses belong to the abandoned path (drop_cnt).
// -----------------------------------------------------------------------------
module fetch_pc_queue
    import fetch_pc_queue_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_BUS,
    parameter int                    DATA_WIDTH = DATA_BUS,
    parameter logic [ADDR_WIDTH-1:0] INIT_PC    = ADDR_WIDTH'(INIT_PC_DEFAULT),
    parameter int                    DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] exc_pc,
    input  logic                  branch_flag,
    input  logic [ADDR_WIDTH-1:0] branch_addr,
    output logic                  rom_req,
    input  logic                  rom_gnt,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic                  rom_rvalid,
    input  logic [DATA_WIDTH-1:0] rom_rdata,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [ADDR_WIDTH-1:0] id_pc,
    output logic [DATA_WIDTH-1:0] id_inst
);

    localparam int PW  = ptr_width(DEPTH);
    localparam int PW1 = PW + 1;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [PW-1:0]         drop_cnt;
    logic [PW-1:0]         count;
    logic [PW-1:0]         unfilled;
    logic [PW-1:0]         drop_next;
    logic [PW:0]           in_flight;
    logic [ADDR_WIDTH-1:0] target;
    logic                  redirect;
    logic                  issue;
    logic                  fill;
    logic                  pop;
    logic                  head_filled;

    assign redirect  = flush | branch_flag;
    assign target    = flush ? exc_pc : branch_addr;

    // Queued entries plus abandoned responses bound the outstanding requests.
    assign in_flight = {1'b0, count} + {1'b0, drop_cnt};
    assign rom_req   = !rst && !redirect && (in_flight < PW1'(DEPTH));
    assign rom_addr  = fetch_pc;
    assign issue     = rom_req && rom_gnt;

    // A response only fills the queue when nothing is pending to be dropped.
    assign fill      = rom_rvalid && (drop_cnt == '0) && !redirect && !rst;
    assign pop       = id_valid && id_ready && !redirect;

    // Every unfilled entry still has a response on its way; the one arriving
    // this cycle (stale or not) is consumed right now.
    assign drop_next = drop_cnt + unfilled - PW'(rom_rvalid);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= INIT_PC;
            drop_cnt <= '0;
        end else if (redirect) begin
            fetch_pc <= target;
            drop_cnt <= drop_next;
        end else begin
            if (issue) fetch_pc <= fetch_pc + ADDR_WIDTH'(PC_STEP);
            if (rom_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - PW'(1);
        end
    end

    fetch_queue #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .clear       (redirect),
        .alloc       (issue),
        .alloc_pc    (fetch_pc),
        .fill        (fill),
        .fill_inst   (rom_rdata),
        .pop         (pop),
        .count       (count),
        .unfilled    (unfilled),
        .head_pc     (id_pc),
        .head_inst   (id_inst),
        .head_filled (head_filled)
    );

    assign id_valid = !rst && (count != '0) && head_filled;

endmodule

// File: tb/tb_fetch_pc_queue.sv
module tb_fetch_pc_queue;
    import fetch_pc_queue_pkg::*;

    localparam int          AW      = 32;
    localparam int          DW      = 32;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] TB_INIT = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] exc_pc = '0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        rom_req;
    logic        rom_gnt = 1'b0;
    logic [31:0] rom_addr;
    logic        rom_rvalid = 1'b0;
    logic [31:0] rom_rdata = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    fetch_pc_queue #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .INIT_PC    (TB_INIT),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .exc_pc      (exc_pc),
        .branch_flag (branch_flag),
        .branch_addr (branch_addr),
        .rom_req     (rom_req),
        .rom_gnt     (rom_gnt),
        .rom_addr    (rom_addr),
        .rom_rvalid  (rom_rvalid),
        .rom_rdata   (rom_rdata),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_inst     (id_inst)
    );

    always #5 clk = ~clk;

    // ROM requests still owed a response, and the instructions ID should see.
    typedef struct { logic [31:0] addr; int due; int epoch; } rom_ent_t;
    typedef struct { logic [31:0] pc; bit got; } exp_ent_t;
    typedef struct {
        bit rst; bit gnt; bit ready;
        bit req; logic [31:0] addr; bit valid; logic [31:0] pc;
    } vec_t;

    rom_ent_t    romq[$];
    exp_ent_t    expq[$];
    int          cur_epoch = 0;
    int          last_due  = 0;
    int          cyc       = 0;
    int          n_checks  = 0;
    int          n_errs    = 0;
    int          lat_min   = 1;
    int          lat_jit   = 0;
    logic [31:0] model_pc  = TB_INIT;

    bit          t_rst = 1'b1, t_flush = 1'b0, t_br = 1'b0, t_gnt = 1'b0, t_ready = 1'b0;
    logic [31:0] t_exc = '0, t_baddr = '0;

    bit          s_req, s_valid, s_issue, s_pop;
    logic [31:0] s_addr, s_pc, s_inst;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs and the ROM at the falling edge, sample and
    // compare against the reference model, then advance the model.
    task automatic cycle();
        bit       redir, exp_req, exp_valid, marked;
        int       n_stale, due;
        rom_ent_t r;
        @(negedge clk);
        rst         = t_rst;
        flush       = t_flush;
        exc_pc      = t_exc;
        branch_flag = t_br;
        branch_addr = t_baddr;
        rom_gnt     = t_gnt;
        id_ready    = t_ready;
        rom_rvalid  = !t_rst && (romq.size() > 0) && (romq[0].due <= cyc);
        rom_rdata   = rom_rvalid ? rom_word(romq[0].addr) : 32'hDEAD_BEEF;
        #1;
        s_req   = rom_req;
        s_addr  = rom_addr;
        s_valid = id_valid;
        s_pc    = id_pc;
        s_inst  = id_inst;

        redir   = t_flush || t_br;
        n_stale = 0;
        foreach (romq[i]) if (romq[i].epoch != cur_epoch) n_stale++;
        exp_req   = !t_rst && !redir && ((expq.size() + n_stale) < DEPTH);
        exp_valid = !t_rst && (expq.size() > 0) && expq[0].got;
        check("rom_req", s_req, exp_req);
        check("id_valid", s_valid, exp_valid);
        if (s_req) check("rom_addr", s_addr, model_pc);
        if (exp_valid && s_valid) begin
            check("id_pc", s_pc, expq[0].pc);
            check("id_inst", s_inst, rom_word(expq[0].pc));
        end

        s_issue = s_req && t_gnt;
        s_pop   = s_valid && t_ready && !redir && !t_rst;
        if (t_rst) begin
            romq.delete();
            expq.delete();
            model_pc = TB_INIT;
            last_due = 0;
        end else begin
            if (rom_rvalid) begin
                r = romq.pop_front();
                if (r.epoch == cur_epoch) begin
                    marked = 1'b0;
                    for (int i = 0; i < expq.size(); i++)
                        if (!marked && !expq[i].got) begin
                            expq[i].got = 1'b1;
                            marked = 1'b1;
                        end
                end
            end
            if (s_pop && expq.size() > 0) void'(expq.pop_front());
            if (s_issue) begin
                due = cyc + lat_min + ((lat_jit > 0) ? int'($urandom_range(lat_jit, 0)) : 0);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                romq.push_back('{s_addr, due, cur_epoch});
                expq.push_back('{model_pc, 1'b0});
                model_pc = model_pc + 32'd4;
            end
            if (redir) begin
                cur_epoch++;
                expq.delete();
                model_pc = t_flush ? t_exc : t_baddr;
            end
        end
        cyc++;
    endtask

    task automatic drain();
        bit done = 1'b0;
        t_rst = 1'b0; t_flush = 1'b0; t_br = 1'b0; t_gnt = 1'b0; t_ready = 1'b1;
        for (int k = 0; k < 60 && !done; k++) begin
            cycle();
            done = (romq.size() == 0) && (expq.size() == 0);
        end
        check("drain_done", done, 1);
    endtask

    task automatic find_first_pop(input string name, input logic [31:0] want);
        bit found = 1'b0;
        for (int k = 0; k < 25 && !found; k++) begin
            cycle();
            if (s_pop) begin
                found = 1'b1;
                check(name, s_pc, want);
            end
        end
        check({name, "_seen"}, found, 1);
    endtask

    vec_t        vecs[8];
    logic [31:0] hold_pc;
    logic [31:0] issued[$];
    logic [31:0] wrap_exp[3];
    bit          full_seen;
    int          r;

    initial begin
        // Reset for 3 cycles, then a 1-cycle ROM with grant and ready held high.
        vecs[0] = '{1, 0, 0, 0, 32'h0,           0, 32'h0};
        vecs[1] = '{1, 0, 0, 0, 32'h0,           0, 32'h0};
        vecs[2] = '{1, 0, 0, 0, 32'h0,           0, 32'h0};
        vecs[3] = '{0, 1, 1, 1, TB_INIT,         0, 32'h0};
        vecs[4] = '{0, 1, 1, 1, TB_INIT + 4,     0, 32'h0};
        vecs[5] = '{0, 1, 1, 1, TB_INIT + 8,     1, TB_INIT};
        vecs[6] = '{0, 1, 1, 1, TB_INIT + 12,    1, TB_INIT + 4};
        vecs[7] = '{0, 1, 1, 1, TB_INIT + 16,    1, TB_INIT + 8};
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;

        for (int i = 0; i < 8; i++) begin
            t_rst = vecs[i].rst; t_gnt = vecs[i].gnt; t_ready = vecs[i].ready;
            cycle();
            check("vec_req", s_req, vecs[i].req);
            check("vec_valid", s_valid, vecs[i].valid);
            if (vecs[i].req)   check("vec_addr", s_addr, vecs[i].addr);
            if (vecs[i].valid) check("vec_pc", s_pc, vecs[i].pc);
        end

        // ID stall: queue fills, head held, then four in-order pops.
        for (int k = 0; k < 3; k++) cycle();
        t_ready = 1'b0;
        cycle();
        hold_pc = s_pc;
        for (int k = 0; k < 8; k++) cycle();
        check("stall_req_low", s_req, 0);
        check("stall_pc_hold", s_pc, hold_pc);
        check("stall_inst_hold", s_inst, rom_word(hold_pc));
        t_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("stall_pop_valid", s_valid, 1);
            check("stall_pop_pc", s_pc, hold_pc + 32'(4 * k));
        end

        // Branch with two requests outstanding on a 3-cycle ROM.
        drain();
        lat_min = 3;
        t_gnt = 1'b1;
        cycle();
        cycle();
        t_gnt = 1'b0; t_br = 1'b1; t_baddr = 32'h0000_0100;
        cycle();
        t_br = 1'b0; t_gnt = 1'b1;
        find_first_pop("branch_first_pc", 32'h0000_0100);

        // Flush and branch together, with a response arriving in that cycle.
        drain();
        t_gnt = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        t_gnt = 1'b0; t_flush = 1'b1; t_br = 1'b1;
        t_exc = 32'h0000_0380; t_baddr = 32'h0000_0200;
        cycle();
        t_flush = 1'b0; t_br = 1'b0;
        cycle();
        check("flush_drop_cnt", 64'(dut.drop_cnt), 2);
        t_gnt = 1'b1;
        find_first_pop("flush_first_pc", 32'h0000_0380);

        // Address wrap under random grant backpressure; redirect latency.
        drain();
        lat_min = 1;
        t_br = 1'b1; t_baddr = 32'hFFFF_FFF8;
        cycle();
        t_br = 1'b0; t_gnt = 1'b1;
        cycle();
        check("redir_req_next", s_req, 1);
        if (s_issue) issued.push_back(s_addr);
        t_gnt = $urandom_range(1, 0) != 0;
        cycle();
        if (s_issue) issued.push_back(s_addr);
        cycle();
        check("redir_valid_latency", s_valid, 1);
        if (s_issue) issued.push_back(s_addr);
        for (int k = 0; k < 30; k++) begin
            t_gnt = $urandom_range(1, 0) != 0;
            cycle();
            if (s_issue) issued.push_back(s_addr);
        end
        check("wrap_issue_count", issued.size() >= 3, 1);
        for (int k = 0; k < 3; k++)
            if (k < issued.size()) check("wrap_addr", issued[k], wrap_exp[k]);

        // Random traffic: grant/ready backpressure, jittered latency, redirects.
        lat_jit = 2;
        for (int k = 0; k < 300; k++) begin
            t_gnt   = $urandom_range(3, 0) != 0;
            t_ready = $urandom_range(3, 0) != 0;
            r       = int'($urandom_range(15, 0));
            t_flush = (r == 0) || (r == 3);
            t_br    = (r <= 2);
            t_exc   = $urandom & 32'hFFFF_FFFC;
            t_baddr = $urandom & 32'hFFFF_FFFC;
            cycle();
        end
        t_flush = 1'b0; t_br = 1'b0; lat_jit = 0;

        // Reset with a full queue.
        t_ready = 1'b0; t_gnt = 1'b1;
        full_seen = 1'b0;
        for (int k = 0; k < 25 && !full_seen; k++) begin
            cycle();
            full_seen = !s_req && s_valid;
        end
        check("full_before_rst", full_seen, 1);
        t_rst = 1'b1;
        cycle();
        check("rst_req_low", s_req, 0);
        cycle();
        check("rst_valid_low", s_valid, 0);
        check("rst_req_low2", s_req, 0);
        t_rst = 1'b0; t_ready = 1'b1;
        cycle();
        check("rst_first_req", s_req, 1);
        check("rst_first_addr", s_addr, TB_INIT);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
